// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers and returns
// read data or a timeout error on a valid/ready response channel. One transfer in flight.
module apb_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    // Counter value on the last ACCESS cycle allowed before giving up.
    localparam logic [7:0] TimeoutLast =
        8'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [7:0]            cnt_q, cnt_d;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            StIdle: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    psel_d   = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TimeoutLast) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table against a small register-slave model,
// plus hand sequences for timeout, response backpressure, mid-transfer reset and no-timeout.
module tb_apb_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY;

    // Second instance with the timeout disabled.
    logic        c0_valid, c0_ready, c0_write;
    logic [31:0] c0_addr, c0_wdata;
    logic        r0_valid, r0_ready, r0_err;
    logic [31:0] r0_rdata;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p0_sel, p0_enable, p0_write, p0_ready;

    always #5 PCLK = ~PCLK;

    apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_write(c0_write),
        .cmd_addr(c0_addr), .cmd_wdata(c0_wdata),
        .rsp_valid(r0_valid), .rsp_ready(r0_ready), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
        .PADDR(p0_addr), .PSEL(p0_sel), .PENABLE(p0_enable), .PWRITE(p0_write),
        .PWDATA(p0_wdata), .PRDATA(p0_rdata), .PREADY(p0_ready)
    );

    // Register slave model: 16 words, configurable wait states, optional forced PREADY.
    logic [31:0] mem [16];
    logic [7:0]  slave_waits = 8'd0;
    logic [7:0]  wcnt;
    logic        force_en = 1'b0;
    logic        force_val = 1'b0;

    assign PRDATA = mem[PADDR[5:2]];
    assign PREADY = force_en ? force_val : (PSEL && PENABLE && (wcnt == slave_waits));

    always @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            wcnt <= 8'd0;
        end else begin
            if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 8'd1;
            else wcnt <= 8'd0;
            if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
        end
    end

    // Protocol monitor: SETUP leads to ACCESS, address/data stable while selected.
    int          proto_err = 0;
    logic        p_preset = 1'b1, p_psel = 1'b0, p_penable = 1'b0, p_pready = 1'b0;
    logic        p_pwrite = 1'b0;
    logic [31:0] p_paddr = 32'h0, p_pwdata = 32'h0;

    always @(negedge PCLK) begin
        if (!p_preset && p_psel) begin
            if (PSEL && (PADDR !== p_paddr || PWDATA !== p_pwdata || PWRITE !== p_pwrite))
                proto_err++;
            if (!p_penable && !(PSEL && PENABLE)) proto_err++;
            if (p_penable && p_pready && PSEL) proto_err++;
        end
        p_preset  = PRESET;
        p_psel    = PSEL;
        p_penable = PENABLE;
        p_pready  = PREADY;
        p_pwrite  = PWRITE;
        p_paddr   = PADDR;
        p_pwdata  = PWDATA;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  waits;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic xfer(input vec_t v, input int idx);
        int n;
        slave_waits = v.waits;
        cmd_valid = 1'b1;
        cmd_write = v.w;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        chk($sformatf("v%0d cmd_ready", idx), {31'h0, cmd_ready}, 32'h1);
        step();
        cmd_valid = 1'b0;
        cmd_wdata = 32'hFFFF_FFFF;
        chk($sformatf("v%0d setup psel/penable", idx), {30'h0, PSEL, PENABLE}, 32'h2);
        chk($sformatf("v%0d paddr", idx), PADDR, v.addr);
        chk($sformatf("v%0d pwrite", idx), {31'h0, PWRITE}, {31'h0, v.w});
        chk($sformatf("v%0d pwdata", idx), PWDATA, v.w ? v.wdata : 32'h0);
        n = 0;
        while (!rsp_valid && n < 100) begin step(); n++; end
        // Response registered on the edge that samples PREADY: 2 edges after accept + waits.
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(2 + int'(v.waits)));
        chk($sformatf("v%0d rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), {31'h0, rsp_err}, 32'h0);
        chk($sformatf("v%0d psel after", idx), {31'h0, PSEL}, 32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_valid cleared", idx), {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 8'd0,  32'h0};
        vecs[1]  = '{1'b1, 32'h04, 32'h1234_5678, 8'd1,  32'h0};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,         8'd3,  32'h1234_5678};
        vecs[3]  = '{1'b0, 32'h10, 32'h0,         8'd0,  32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'h08, 32'hA5A5_5A5A, 8'd2,  32'h0};
        vecs[5]  = '{1'b0, 32'h08, 32'hFFFF_0000, 8'd0,  32'hA5A5_5A5A};
        vecs[6]  = '{1'b1, 32'h10, 32'h0000_0001, 8'd0,  32'h0};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,         8'd1,  32'h0000_0001};
        vecs[8]  = '{1'b0, 32'h0C, 32'h0,         8'd0,  32'h0};
        vecs[9]  = '{1'b0, 32'h04, 32'h0,         8'd0,  32'h1234_5678};
        // PREADY on the final timeout cycle counts as success.
        vecs[10] = '{1'b0, 32'h08, 32'h0,         8'd15, 32'hA5A5_5A5A};

        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        c0_valid = 1'b0; c0_write = 1'b0; c0_addr = 32'h0; c0_wdata = 32'h0;
        r0_ready = 1'b0; p0_rdata = 32'h0; p0_ready = 1'b0;
        repeat (3) step();
        PRESET = 1'b0;

        chk("reset psel/penable/rsp_valid/rsp_err",
            {28'h0, PSEL, PENABLE, rsp_valid, rsp_err}, 32'h0);
        chk("reset paddr", PADDR, 32'h0);
        chk("reset pwdata", PWDATA, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);

        for (int i = 0; i < 11; i++) xfer(vecs[i], i);

        // PREADY outside ACCESS has no effect.
        force_en = 1'b1; force_val = 1'b1;
        repeat (2) step();
        chk("idle pready ignored", {30'h0, PSEL, rsp_valid}, 32'h0);

        // Timeout: PREADY stuck low.
        force_val = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        step();
        cmd_valid = 1'b0;
        step();
        n = 0;
        while (PENABLE && n < 100) begin step(); n++; end
        chk("timeout access cycles", 32'(n), 32'd16);
        chk("timeout rsp_valid/err", {30'h0, rsp_valid, rsp_err}, 32'h3);
        chk("timeout rdata", rsp_rdata, 32'h0);
        chk("timeout psel", {31'h0, PSEL}, 32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        force_en = 1'b0;

        // Response backpressure with a competing command pending.
        slave_waits = 8'd0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
        step();
        cmd_write = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'h0000_0055;
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d cmd_ready", i), {31'h0, cmd_ready}, 32'h0);
            chk($sformatf("bp%0d rsp_valid", i), {31'h0, rsp_valid}, 32'h1);
            chk($sformatf("bp%0d rsp_rdata", i), rsp_rdata, 32'h0000_0001);
            chk($sformatf("bp%0d paddr held", i), PADDR, 32'h10);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp idle cmd_ready", {30'h0, cmd_ready, PSEL}, 32'h2);
        step();
        cmd_valid = 1'b0;
        chk("bp next accepted", {30'h0, PSEL, PWRITE}, 32'h3);
        chk("bp next paddr", PADDR, 32'h14);
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset in the middle of ACCESS.
        force_en = 1'b1; force_val = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'h77;
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        chk("pre-reset in access", {30'h0, PSEL, PENABLE}, 32'h3);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        chk("reset abort outputs", {29'h0, PSEL, PENABLE, rsp_valid}, 32'h0);
        chk("reset abort cmd_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (3) step();
        chk("reset abort no response", {31'h0, rsp_valid}, 32'h0);
        force_en = 1'b0;

        // No timeout: waits as long as the slave stalls.
        c0_valid = 1'b1; c0_write = 1'b0; c0_addr = 32'h40;
        step();
        c0_valid = 1'b0;
        repeat (40) step();
        chk("no-timeout still waiting", {29'h0, p0_sel, p0_enable, r0_valid}, 32'h6);
        p0_rdata = 32'hCAFE_0000;
        p0_ready = 1'b1;
        step();
        p0_ready = 1'b0;
        chk("no-timeout rsp", {30'h0, r0_valid, r0_err}, 32'h2);
        chk("no-timeout rdata", r0_rdata, 32'hCAFE_0000);
        r0_ready = 1'b1;
        step();
        r0_ready = 1'b0;

        chk("protocol monitor", 32'(proto_err), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
